expression_fsm: RTL and testbench

Serial checker for single-digit infix arithmetic expressions. It takes one ASCII character per clock and flags whether the characters received since the last clear form a legal expression. A legal expression alternates single digits and binary operators, starting and ending with a digit. The block is a self-contained Moore FSM; upstream logic streams characters into it, and downstream logic samples the verdict.

---
 rtl/expression_pkg.sv | 25 ++
 rtl/expr_char_class.sv | 21 ++
 rtl/expression_fsm.sv | 52 +++++
 tb/tb_expression_fsm.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/expression_pkg.sv
// Shared types and constants for the serial infix-expression checker.
// Contents:
//   state_t      - FSM state encoding (S_START / S_DIGIT / S_ERR), 2 bits
//   char_class_t - character class produced by the classifier (DIGIT / OP / OTHER)
//   ASCII_*      - character codes the classifier decodes
package expression_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_DIGIT = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIGIT = 2'd0,
        OP    = 2'd1,
        OTHER = 2'd2
    } char_class_t;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_STAR = 8'h2A;

endpackage

// File: rtl/expr_char_class.sv
// Purely combinational character classifier.
// Ports:
//   in  - 8-bit ASCII character
//   cls - DIGIT for '0'..'9', OP for '+' or '*', OTHER for every other code
module expr_char_class
    import expression_pkg::*;
(
    input  logic [7:0]  in,
    output char_class_t cls
);

    always_comb begin
        cls = OTHER;
        if (in >= ASCII_0 && in <= ASCII_9) begin
            cls = DIGIT;
        end else if (in == ASCII_PLUS || in == ASCII_STAR) begin
            cls = OP;
        end
    end

endmodule

// File: rtl/expression_fsm.sv
// Moore FSM that checks, one ASCII character per clock, whether the characters
// received since the last clear form a legal single-digit infix expression
// (digit, op, digit, ..., digit with op in {+, *}).
// Ports:
//   clk - system clock, rising edge
//   clr - asynchronous active-low clear; holds the FSM in S_START while low
//   in  - character consumed on every rising edge while clr is high
//   out - 1 only in S_DIGIT (legal, complete expression so far)
module expression_fsm
    import expression_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] in,
    output logic       out
);

    state_t      state_q;
    state_t      state_d;
    char_class_t cls;

    expr_char_class u_char_class (
        .in  (in),
        .cls (cls)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_ERR;
        unique case (state_q)
            S_START: begin
                if (cls == DIGIT) state_d = S_DIGIT;
            end
            S_DIGIT: begin
                if (cls == OP) state_d = S_START;
            end
            S_ERR:   state_d = S_ERR;
            // Unused encoding falls into the sticky error state.
            default: state_d = S_ERR;
        endcase
    end

    assign out = (state_q == S_DIGIT);

endmodule

// File: tb/tb_expression_fsm.sv
// Self-checking bench for expression_fsm: a directed vector table, hand-written
// asynchronous-clear sequences, and a randomized stream checked against a model
// that judges the whole history string since the last clear.
module tb_expression_fsm;

    logic       clk;
    logic       clr;
    logic [7:0] din;
    logic       dout;

    int checks;
    int errors;

    logic [7:0] hist[$];

    expression_fsm dut (
        .clk (clk),
        .clr (clr),
        .in  (din),
        .out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr_first;
        logic [7:0] ch;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: out=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    // Legal iff non-empty, odd length, digits on even positions, ops on odd.
    function automatic logic model_ok();
        if (hist.size() == 0 || hist.size() % 2 == 0) return 1'b0;
        for (int i = 0; i < hist.size(); i++) begin
            if (i % 2 == 0) begin
                if (!(hist[i] >= "0" && hist[i] <= "9")) return 1'b0;
            end else begin
                if (!(hist[i] == "+" || hist[i] == "*")) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Drive on the negative edge, sample 1 time unit after the rising edge.
    task automatic send(input logic [7:0] ch, input logic exp, input string name);
        @(negedge clk);
        din = ch;
        @(posedge clk);
        #1;
        check(name, dout, exp);
    endtask

    // Clear spans one rising edge and is released well away from any edge.
    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_async", dout, 1'b0);
        @(posedge clk);
        #1;
        check("clr_held", dout, 1'b0);
        #2;
        clr = 1'b1;
        hist.delete();
    endtask

    task automatic add(input logic c, input logic [7:0] ch, input logic e);
        vec_t v;
        v.clr_first = c;
        v.ch        = ch;
        v.exp       = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] ch;
        logic       exp;
        int         r;

        checks = 0;
        errors = 0;
        clr    = 1'b0;
        din    = 8'h00;

        // Reset: out low while clr is held across several edges.
        #1;
        check("reset_immediate", dout, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", dout, 1'b0);
        #2;
        clr = 1'b1;

        // Directed table.
        add(0, "1", 1); add(0, "+", 0); add(0, "2", 1);
        add(1, "1", 1); add(0, "+", 0); add(0, "+", 0); add(0, "2", 0);
        add(1, "+", 0); add(0, "2", 0);
        add(1, "1", 1); add(0, "2", 0);
        add(1, "1", 1); add(0, "*", 0); add(0, "3", 1); add(0, "+", 0); add(0, "5", 1);
        add(1, "9", 1); add(0, "-", 0); add(0, "0", 0);
        add(1, 8'h00, 0); add(0, "4", 0);
        add(1, "0", 1); add(0, "*", 0); add(0, "/", 0);
        add(1, "9", 1); add(0, "*", 0); add(0, ":", 0);
        add(1, "5", 1); add(0, "+", 0); add(0, "5", 1); add(0, "5", 0);

        foreach (vecs[i]) begin
            if (vecs[i].clr_first) pulse_clr();
            send(vecs[i].ch, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Error, then asynchronous clear recovers.
        pulse_clr();
        send("a", 1'b0, "err_a");
        send("3", 1'b0, "err_sticky");
        pulse_clr();
        send("7", 1'b1, "recover_7");

        // Clear mid-cycle from S_DIGIT: out must drop with no clock edge.
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("midcycle_clr", dout, 1'b0);
        #1;
        clr = 1'b1;
        send("8", 1'b1, "after_midcycle");

        // Randomized stream against the history model.
        hist.delete();
        pulse_clr();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) pulse_clr();
            r = $urandom_range(0, 9);
            if (r < 5)      ch = 8'("0" + $urandom_range(0, 9));
            else if (r < 8) ch = ($urandom_range(0, 1) == 0) ? "+" : "*";
            else            ch = 8'($urandom_range(0, 255));
            hist.push_back(ch);
            exp = model_ok();
            send(ch, exp, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
